// File: rtl/dcache_l2c_req_ctrl.sv
// dcache_l2c_req_ctrl
// Drains MSHR misses into L2 line-fill requests, tracks requests in flight,
// buffers L2 answers in a small FIFO toward the D1 refill path, and discards
// answers that belong to requests issued before an MSHR flush.
module dcache_l2c_req_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ANS_FIFO_DEPTH  = 2,
    parameter int LINE_ADDR_W     = 26,
    parameter int LINE_W          = 128,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   req_available_i,
    input  logic [LINE_ADDR_W-1:0] mshr_line_addr_i,
    input  logic                   mshr_busy_i,
    output logic                   put_wait_read_line_o,
    output logic                   l2c_req_valid_o,
    input  logic                   l2c_req_ready_i,
    output logic [LINE_ADDR_W-1:0] l2c_req_line_addr_o,
    input  logic                   l2c_ans_valid_i,
    output logic                   l2c_ans_ready_o,
    input  logic [LINE_ADDR_W-1:0] l2c_ans_line_addr_i,
    input  logic [LINE_W-1:0]      l2c_ans_line_i,
    output logic                   refill_valid_o,
    input  logic                   refill_ready_i,
    output logic [LINE_ADDR_W-1:0] refill_line_addr_o,
    output logic [LINE_W-1:0]      refill_line_o,
    output logic [OUT_W-1:0]       outstanding_o,
    output logic                   idle_o
);

    localparam int CNT_W = $clog2(ANS_FIFO_DEPTH + 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ANS_FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LINE_ADDR_W-1:0] r_addr;
    logic [OUT_W-1:0]       r_outstanding;
    logic [OUT_W-1:0]       r_drop;
    logic [OUT_W-1:0]       w_drop_reload;

    logic [LINE_ADDR_W-1:0] r_fifo_addr [ANS_FIFO_DEPTH];
    logic [LINE_W-1:0]      r_fifo_line [ANS_FIFO_DEPTH];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic w_fire;
    logic w_req_valid;
    logic w_req_hs;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_ans_fire;
    logic w_push;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && refill_ready_i;
    assign w_req_hs   = w_req_valid && l2c_req_ready_i;
    assign w_ans_fire = l2c_ans_valid_i && l2c_ans_ready_o;
    assign w_push     = w_ans_fire && (r_drop == '0) && !flush_i;

    // A request still parked in ISSUE will be answered later, so it is
    // counted among the answers to discard after a flush.
    assign w_drop_reload = r_outstanding - OUT_W'(w_ans_fire)
                         + OUT_W'(r_state == ST_ISSUE);

    assign put_wait_read_line_o = w_fire;
    assign l2c_req_valid_o      = w_req_valid;
    assign l2c_req_line_addr_o  = r_addr;
    assign l2c_ans_ready_o      = (r_drop != '0) || !w_full || w_pop;
    assign refill_valid_o       = !w_empty;
    assign refill_line_addr_o   = w_empty ? '0 : r_fifo_addr[r_rd_ptr];
    assign refill_line_o        = w_empty ? '0 : r_fifo_line[r_rd_ptr];
    assign outstanding_o        = r_outstanding;
    assign idle_o               = (r_state == ST_IDLE) && (r_outstanding == '0)
                                && (r_drop == '0) && w_empty;

    // Request FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Request FSM: fire marks the MSHR entry in the same cycle its address is latched
    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        w_req_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_available_i && !mshr_busy_i && !flush_i &&
                    (r_outstanding < MAX_OUT)) begin
                    w_fire       = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_req_valid = 1'b1;
                if (l2c_req_ready_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the line address of the entry being drained
    always_ff @(posedge clk_i) begin
        if (rst_i)       r_addr <= '0;
        else if (w_fire) r_addr <= mshr_line_addr_i;
    end

    // Requests in flight: up on request handshake, down on every accepted answer
    always_ff @(posedge clk_i) begin
        if (rst_i) r_outstanding <= '0;
        else       r_outstanding <= r_outstanding + OUT_W'(w_req_hs) - OUT_W'(w_ans_fire);
    end

    // Count of stale answers still to be discarded after a flush
    always_ff @(posedge clk_i) begin
        if (rst_i)                               r_drop <= '0;
        else if (flush_i)                        r_drop <= w_drop_reload;
        else if (w_ans_fire && (r_drop != '0))   r_drop <= r_drop - 1'b1;
    end

    // Answer FIFO pointers and occupancy; a flush empties it
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Answer FIFO storage; data is only observed through the occupancy gate
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= l2c_ans_line_addr_i;
            r_fifo_line[r_wr_ptr] <= l2c_ans_line_i;
        end
    end

    // An answer with nothing in flight means the L2 side broke the protocol
    a_no_orphan_answer: assert property (@(posedge clk_i) disable iff (rst_i)
        (l2c_ans_valid_i && l2c_ans_ready_o) |-> (r_outstanding != '0));

    // The credit counter must stay within its configured limit
    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        r_outstanding <= MAX_OUT);

endmodule
